// File: rtl/sample_mem_arbiter.sv
// sample_mem_arbiter: round-robin arbiter between the sampler (write) and the
//   UART dump (read) in front of a single-command SDRAM controller port.
// Latency: ack is combinational in the grant cycle; the command is presented
//   the next cycle. rd_valid is registered one cycle after data or timeout.
// Backpressure: no grant while mem_ready=0. The command is held until
//   mem_ready is seen low. Only one command is ever in flight.
// Ports: clk100/rst_p (async, active-high); wr_req/wr_addr/wr_data/wr_ack;
//   rd_req/rd_addr/rd_ack/rd_data/rd_valid; mem_* controller command and
//   return path; busy (not IDLE); rd_err (sticky read timeout).
module sample_mem_arbiter #(
  parameter int RD_TIMEOUT = 1023
) (
  input  logic        clk100,
  input  logic        rst_p,
  input  logic        wr_req,
  input  logic [22:0] wr_addr,
  input  logic [31:0] wr_data,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [22:0] rd_addr,
  output logic        rd_ack,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  input  logic        mem_ready,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [22:0] mem_addr,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  input  logic        mem_data_valid,
  output logic        busy,
  output logic        rd_err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RD_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WR_DONE, RD_WAIT} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_wr;   // 1 = previous grant went to the writer
  logic             r_is_wr;     // direction of the command in flight
  logic [CNT_W-1:0] r_cnt;
  logic [22:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [31:0]      r_rd_data;
  logic             r_rd_valid;
  logic             r_rd_err;
  logic             w_grant_wr;
  logic             w_grant_rd;
  logic             w_timeout;

  always_comb begin
    w_next     = r_state;
    w_grant_wr = 1'b0;
    w_grant_rd = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      IDLE: begin
        if (mem_ready) begin
          // Writer wins unless the reader is also waiting and the writer
          // had the last grant.
          if (wr_req && (!rd_req || !r_last_wr)) begin
            w_grant_wr = 1'b1;
          end else if (rd_req) begin
            w_grant_rd = 1'b1;
          end
          if (w_grant_wr || w_grant_rd) begin
            w_next = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Controller signals acceptance by dropping mem_ready.
        if (!mem_ready) begin
          w_next = r_is_wr ? WR_DONE : RD_WAIT;
        end
      end
      WR_DONE: begin
        if (mem_ready) begin
          w_next = IDLE;
        end
      end
      RD_WAIT: begin
        // Real data takes priority over a timeout landing in the same cycle.
        if (mem_data_valid) begin
          w_next = IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk100 or posedge rst_p) begin
    if (rst_p) begin
      r_state    <= IDLE;
      r_last_wr  <= 1'b0;
      r_is_wr    <= 1'b0;
      r_cnt      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_rd_valid <= 1'b0;
      if (w_grant_wr) begin
        r_last_wr <= 1'b1;
        r_is_wr   <= 1'b1;
        r_addr    <= wr_addr;
        r_wdata   <= wr_data;
      end else if (w_grant_rd) begin
        r_last_wr <= 1'b0;
        r_is_wr   <= 1'b0;
        r_addr    <= rd_addr;
      end
      // Held at zero outside RD_WAIT, so it is zero on the first wait cycle.
      if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt <= '0;
      end
      if (r_state == RD_WAIT) begin
        if (mem_data_valid) begin
          r_rd_data  <= mem_data_out;
          r_rd_valid <= 1'b1;
        end else if (w_timeout) begin
          r_rd_data  <= 32'hFFFF_FFFF;
          r_rd_valid <= 1'b1;
          r_rd_err   <= 1'b1;
        end
      end
    end
  end

  // Acks are combinational; masked during reset so outputs stay low.
  assign wr_ack      = w_grant_wr & ~rst_p;
  assign rd_ack      = w_grant_rd & ~rst_p;
  assign mem_enable  = (r_state == ISSUE);
  assign mem_wr      = (r_state == ISSUE) & r_is_wr;
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign rd_data     = r_rd_data;
  assign rd_valid    = r_rd_valid;
  assign busy        = (r_state != IDLE);
  assign rd_err      = r_rd_err;

endmodule

// File: doc/sample_mem_arbiter.md
SAMPLE_MEM_ARBITER -- requirements
Module: sample_mem_arbiter

Interface
REQ-001 Parameter RD_TIMEOUT, default 1023: maximum cycles to wait in RD_WAIT for read data.
REQ-002 clk100  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-003 rst_p  input  1  reset, asynchronous, active-high.
REQ-004 wr_req  input  1  write requester (sampler) holds high until wr_ack.
REQ-005 wr_addr  input  23  write word address; wr_data  input  32  write word.
REQ-006 wr_ack  output  1  one-cycle pulse: write request granted and latched.
REQ-007 rd_req  input  1  read requester (UART dump) holds high until rd_ack; rd_addr  input  23  read word address.
REQ-008 rd_ack  output  1  one-cycle pulse: read request granted and latched.
REQ-009 rd_data  output  32  read result; rd_valid  output  1  one-cycle pulse when rd_data is valid.
REQ-010 mem_ready  input  1  SDRAM controller command ready; mem_enable  output  1  command strobe; mem_wr  output  1  1 = write, 0 = read.
REQ-011 mem_addr  output  23 and mem_data_in  output  32: command address and write data.
REQ-012 mem_data_out  input  32 and mem_data_valid  input  1: controller read data and its valid pulse.
REQ-013 busy  output  1  high in every state except IDLE; rd_err  output  1  sticky read-timeout flag.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WR_DONE, RD_WAIT.
REQ-015 IDLE: when mem_ready=1 and a request is pending, the block SHALL grant, latch that requester's addr (and data for writes) into mem_addr/mem_data_in, pulse the matching ack in the same cycle, and go to ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: if both requests are pending, the one not granted last wins; after reset, write wins.
REQ-017 If only one request is pending, it SHALL be granted regardless of history.
REQ-018 ISSUE: mem_enable=1 with mem_wr set per grant; on the first cycle mem_ready is sampled 0, the command is accepted, mem_enable SHALL drop next cycle, and the FSM goes to WR_DONE (write) or RD_WAIT (read).
REQ-019 WR_DONE: the FSM SHALL return to IDLE when mem_ready=1; no new grant occurs in that same cycle.
REQ-020 RD_WAIT: on mem_data_valid=1, rd_data<=mem_data_out, rd_valid pulses 1 cycle, and the FSM returns to IDLE.
REQ-021 RD_WAIT timeout: a counter cleared on entry SHALL count cycles; at RD_TIMEOUT cycles without mem_data_valid, rd_data<=32'hFFFFFFFF, rd_valid pulses, rd_err<=1, and the FSM returns to IDLE.
REQ-022 mem_data_valid outside RD_WAIT SHALL be ignored.
REQ-023 A request deasserted before its ack SHALL NOT be granted; a request deasserted after its ack has no effect on the operation in flight.
REQ-024 mem_addr/mem_data_in SHALL stay stable from grant until the FSM leaves ISSUE.
REQ-025 At most one command SHALL be outstanding, and the arbiter SHALL never assert wr_ack and rd_ack in the same cycle.

Reset
REQ-026 While rst_p=1, all outputs SHALL be 0 (mem_addr, mem_data_in, rd_data cleared), state=IDLE, last-grant=read (so write wins next), timeout counter=0, rd_err=0.
REQ-027 rst_p asserted mid-operation SHALL abort immediately; mem_enable=0 with no completion pulse; the requester re-requests after reset.

Verification
REQ-028 Write only: wr_req=1, wr_addr=0x000010, wr_data=0xDEADBEEF, mem_ready=1 -> wr_ack one cycle, then mem_enable=1, mem_wr=1, mem_addr=0x000010, mem_data_in=0xDEADBEEF until mem_ready falls.
REQ-029 Read only: rd_addr=0x7FFFFF; model returns 0x12345678 with mem_data_valid 5 cycles after accept -> rd_valid one cycle, rd_data=0x12345678, busy=0 afterward.
REQ-030 Contention: wr_req and rd_req held continuously -> grants alternate W,R,W,R starting with write after reset.
REQ-031 Timeout: read accepted, mem_data_valid never asserts -> after exactly 1023 cycles in RD_WAIT, rd_valid=1, rd_data=0xFFFFFFFF, rd_err=1 stays set.
REQ-032 Reset mid-read: rst_p pulses in RD_WAIT -> all outputs 0 immediately, no rd_valid, next contention grants write first.
